load_align_unit: RTL and testbench
==================================

# load_align_unit

Load-side memory stage for the accelerator's data path. It accepts byte/half/word load requests, issues word-aligned reads to a fixed-latency or variable-latency in-order memory port, and returns aligned, sign- or zero-extended 32-bit results in request order over a valid/ready handshake. It sits between the load issuer and the data memory, and it performs the alignment that the downstream consumers expect.

## Interface
- DEPTH, 4: maximum number of outstanding requests (power of two, ≥2)
- ADDR_WIDTH, 32: byte address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_rsp_valid  in  1  read data returned, in order, no backpressure
- mem_rsp_data  in  32  read word
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  aligned, extended result
- rsp_err  out  1  misaligned request (only with the macro)

## Operation
- Meta FIFO (DEPTH entries) holds {offset[1:0], size, unsigned, err} per accepted request. Data FIFO (DEPTH entries) holds mem_rsp_data.
- Acceptance rule: req_ready = ~meta_full & (err_now | mem_req_ready). mem_req_valid = req_valid & ~meta_full & ~err_now. Both are combinational. A request is pushed to the meta FIFO on acceptance.
- A full meta FIFO blocks acceptance even when a pop happens in the same cycle. A slot freed by a pop becomes usable the next cycle.
- The data FIFO cannot overflow, because each non-err meta entry produces at most one data entry. A mem_rsp_valid that arrives with no outstanding read is a protocol violation and the bench flags it.
- Output register: it is loaded from the FIFO heads when it is empty or rsp_ready=1. The meta head is popped when it is an err entry, or when it is a normal entry and the data FIFO is non-empty (both FIFOs pop together). Otherwise rsp_valid deasserts.
- Extraction:
  - byte = word[offset*8 +: 8]
  - half = offset[1] ? word[31:16] : word[15:0]
  - word = word
  - Extension is by bit 7 or bit 15, or by zero when req_unsigned=1.
- Err entries produce rsp_data=0 and rsp_err=1 and make no memory access.
- Results are always returned in acceptance order, including when err and normal entries are interleaved.

## Timing
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - Both FIFOs are empty.
  - req_ready is derived from empty state and the err/mem_req_ready inputs.
  - mem_req_valid=0 while req_valid=0.
- Normal load accepted at cycle T with response at T+L: rsp_valid rises at T+L+1 at the earliest.
- Err load accepted at T: rsp_valid at T+1 at the earliest.
- Throughput is one result per cycle when rsp_ready=1 continuously and the memory keeps up.
- rsp_data and rsp_err are held stable while rsp_valid=1 & rsp_ready=0.
- Reset asserted mid-operation clears all state immediately. Any in-flight memory response after reset deasserts is the memory's responsibility to squash.

## Configuration
- LOAD_MISALIGN_CHECK_EN defined:
  - err_now = (size==01 & offset[0]) | (size[1] & |offset).
  - rsp_err is driven as described above.
- Undefined:
  - err_now = 0 and rsp_err is tied 0.
  - Misaligned half/word loads use the truncated offsets: half picks its half by offset[1], word ignores the offset.

## Structure
- Shared package holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - the meta-entry typedef {offset, size, unsigned, err}
- One sub-module, load_sync_fifo:
  - parameters WIDTH and DEPTH; asynchronous active-low reset
  - push, pop, full and empty signals
  - instantiated twice, once for meta and once for data

## Test plan
- Word load at 0x100, mem returns 0xDEADBEEF after 3 cycles, rsp_ready=1: mem_req_addr=0x100, rsp_data=0xDEADBEEF one cycle after mem_rsp_valid.
- Byte loads at offsets 0..3 on word 0x80FF7F01, signed then unsigned: signed results 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned results 0x01, 0x7F, 0xFF, 0x80.
- Half loads at offsets 0 and 2 on word 0x8001FFFE, signed: 0xFFFFFFFE then 0xFFFF8001.
- Issue DEPTH+1 back-to-back loads with the memory holding responses: req_ready drops after 4 acceptances and recovers the cycle after the first result pops.
- rsp_ready=0 for 5 cycles with 3 results pending: rsp_data is stable and no result is lost or reordered after release.
- With LOAD_MISALIGN_CHECK_EN, sequence word@0x0, word@0x2, byte@0x5: result order ok/err/ok, rsp_err=1 with rsp_data=0 for the second result, and only 2 mem requests issued.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// Shared types for the load alignment unit: size encodings, the per-request
// meta entry kept while a load is outstanding, and the byte/half extractor.
package load_align_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] size;
        logic       isUnsigned;
        logic       err;
    } meta_t;

    localparam int META_WIDTH = $bits(meta_t);

    // Size 2'b11 falls through to the word case on purpose.
    function automatic logic [31:0] alignExtract(input logic [31:0] word, input meta_t meta);
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        logic [31:0] result;
        byteSel = word[{meta.offset, 3'b000} +: 8];
        halfSel = meta.offset[1] ? word[31:16] : word[15:0];
        case (meta.size)
            SIZE_BYTE: result = {{24{byteSel[7] & ~meta.isUnsigned}}, byteSel};
            SIZE_HALF: result = {{16{halfSel[15] & ~meta.isUnsigned}}, halfSel};
            default:   result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_align_unit_fifo.sv
// Small synchronous FIFO used for both the request meta queue and the
// returned read-data queue; pushes when full and pops when empty are ignored.
module load_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign data_o  = storage_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) storage_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/load_align_unit.sv
// Load-side memory stage: issues word-aligned reads and returns aligned,
// extended results in order. Define LOAD_MISALIGN_CHECK_EN to flag misaligned loads.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    logic                  errNow;
    logic                  metaFull;
    logic                  metaEmpty;
    logic                  metaPush;
    logic                  metaPop;
    meta_t                 metaIn;
    meta_t                 metaHead;
    logic [META_WIDTH-1:0] metaHeadBits;
    logic                  dataFull;
    logic                  dataEmpty;
    logic                  dataPush;
    logic                  dataPop;
    logic [31:0]           dataHead;
    logic                  loadOut;
    logic                  headReady;

    logic                  rspValid_q, rspValid_d;
    logic [31:0]           rspData_q,  rspData_d;
    logic                  rspErr_q,   rspErr_d;

`ifdef LOAD_MISALIGN_CHECK_EN
    assign errNow = ((req_size == SIZE_HALF) & req_addr[0]) | (req_size[1] & (|req_addr[1:0]));
`else
    assign errNow = 1'b0;
`endif

    // A full meta queue blocks acceptance even if the head pops this cycle.
    assign req_ready     = ~metaFull & (errNow | mem_req_ready);
    assign mem_req_valid = req_valid & ~metaFull & ~errNow;
    assign mem_req_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign metaPush      = req_valid & req_ready;

    assign metaIn.offset     = req_addr[1:0];
    assign metaIn.size       = req_size;
    assign metaIn.isUnsigned = req_unsigned;
    assign metaIn.err        = errNow;
    assign metaHead          = meta_t'(metaHeadBits);

    load_sync_fifo #(
        .WIDTH (META_WIDTH),
        .DEPTH (DEPTH)
    ) u_metaFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (metaPush),
        .data_i  (metaIn),
        .pop_i   (metaPop),
        .data_o  (metaHeadBits),
        .full_o  (metaFull),
        .empty_o (metaEmpty)
    );

    // Every non-err meta entry yields at most one word, so this never overflows.
    assign dataPush = mem_rsp_valid & ~dataFull;

    load_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_dataFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (dataPush),
        .data_i  (mem_rsp_data),
        .pop_i   (dataPop),
        .data_o  (dataHead),
        .full_o  (dataFull),
        .empty_o (dataEmpty)
    );

    assign loadOut   = ~rspValid_q | rsp_ready;
    assign headReady = ~metaEmpty & (metaHead.err | ~dataEmpty);
    assign metaPop   = loadOut & headReady;
    assign dataPop   = metaPop & ~metaHead.err;

    always_comb begin
        rspValid_d = rspValid_q;
        rspData_d  = rspData_q;
        rspErr_d   = rspErr_q;
        if (loadOut) begin
            rspValid_d = headReady;
            if (headReady) begin
                rspErr_d  = metaHead.err;
                rspData_d = metaHead.err ? 32'h0 : alignExtract(dataHead, metaHead);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspValid_q <= 1'b0;
            rspData_q  <= 32'h0;
            rspErr_q   <= 1'b0;
        end else begin
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspErr_q   <= rspErr_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed cases plus random traffic
// against an in-bench memory and load-semantics reference model.
module tb_load_align_unit;

    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 32;
`ifdef LOAD_MISALIGN_CHECK_EN
    localparam int MISALIGN_MEM_REQS = 2;
`else
    localparam int MISALIGN_MEM_REQS = 3;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_unsigned;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;

    stim_t       stimQ[$];
    exp_t        expQ[$];
    pend_t       memPending[$];
    logic [31:0] memArr [0:255];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int acceptedCount = 0;
    int memReqCount = 0;
    int rspCount = 0;
    int firstRspCycle = -1;
    int lastAcceptCycle = -1;
    bit issueEnable = 1'b0;
    bit memHold = 1'b0;
    bit memReadyRandom = 1'b0;
    bit reqIdleRandom = 1'b0;
    int rspReadyMode = 0;
    int minLat = 1;
    int maxLat = 1;

    always #5 clk = ~clk;

    load_align_unit #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    // Reference load semantics computed with plain arithmetic on the bench memory.
    function automatic exp_t modelLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] v;
        int          off;
        word   = memArr[addr[9:2]];
        off    = int'(addr % 32'd4);
        e.err  = 1'b0;
        e.data = 32'h0;
`ifdef LOAD_MISALIGN_CHECK_EN
        if ((size == 2'd1 && (off % 2) == 1) || (size >= 2'd2 && off != 0)) begin
            e.err = 1'b1;
            return e;
        end
`endif
        if (size == 2'd0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (off >= 2) ? (word >> 16) : (word & 32'hFFFF);
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        e.data = v;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        stim_t s;
        s.addr = addr;
        s.size = size;
        s.uns  = uns;
        stimQ.push_back(s);
    endtask

    // One call = n clock cycles of driving requests, memory and consumer.
    task automatic applyStimulus(input int n);
        logic [31:0] a;
        pend_t       p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycle++;
            if (issueEnable && stimQ.size() > 0 && !(reqIdleRandom && $urandom_range(0, 3) == 0)) begin
                req_valid    = 1'b1;
                req_addr     = stimQ[0].addr;
                req_size     = stimQ[0].size;
                req_unsigned = stimQ[0].uns;
            end else begin
                req_valid    = 1'b0;
                req_addr     = $urandom;
                req_size     = 2'($urandom_range(0, 3));
                req_unsigned = 1'($urandom_range(0, 1));
            end
            mem_req_ready = memReadyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rspReadyMode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
            if (!memHold && memPending.size() > 0 && memPending[0].due <= cycle) begin
                a             = memPending[0].addr;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = memArr[a[9:2]];
                void'(memPending.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
            end
            #1;
            if (req_valid && req_ready) begin
                expQ.push_back(modelLoad(req_addr, req_size, req_unsigned));
                void'(stimQ.pop_front());
                acceptedCount++;
                lastAcceptCycle = cycle;
            end
            if (mem_req_valid && mem_req_ready) begin
                checkOutput("memReqAddr", mem_req_addr, req_addr & 32'hFFFF_FFFC);
                memReqCount++;
                p.addr = req_addr;
                p.due  = cycle + int'($urandom_range(minLat, maxLat));
                memPending.push_back(p);
            end
        end
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n;
        n = 0;
        while ((stimQ.size() != 0 || expQ.size() != 0 || memPending.size() != 0) && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checks++;
        if (stimQ.size() != 0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_%s: got %0d unissued and %0d unanswered loads, expected 0",
                     name, stimQ.size(), expQ.size());
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted result.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRsp: got data 0x%08h, expected no response", rsp_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspData", rsp_data, e.data);
                checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
            end
            rspCount++;
            if (firstRspCycle < 0) firstRspCycle = cycle;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int base;
        req_valid     = 1'b0;
        req_addr      = 32'h0;
        req_size      = 2'b00;
        req_unsigned  = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        rsp_ready     = 1'b1;
        for (int i = 0; i < 256; i++) memArr[i] = $urandom;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetRspData", rsp_data, 32'd0);
        checkOutput("resetRspErr", 32'(rsp_err), 32'd0);
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetMemReqValid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issueEnable = 1'b1;

        $display("[TB] word load, 3-cycle memory");
        memArr[8'h40] = 32'hDEAD_BEEF;
        minLat = 3; maxLat = 3;
        base = memReqCount;
        pushLoad(32'h100, 2'b10, 1'b0);
        waitDrain(50, "wordLoad");
        checkOutput("wordLoadMemReqs", 32'(memReqCount - base), 32'd1);

        $display("[TB] byte loads, signed then unsigned");
        memArr[8'h80] = 32'h80FF_7F01;
        minLat = 1; maxLat = 2;
        for (int u = 0; u < 2; u++)
            for (int off = 0; off < 4; off++)
                pushLoad(32'h200 + 32'(off), 2'b00, 1'(u));
        waitDrain(100, "byteLoads");

        $display("[TB] signed half loads");
        memArr[8'hC0] = 32'h8001_FFFE;
        pushLoad(32'h300, 2'b01, 1'b0);
        pushLoad(32'h302, 2'b01, 1'b0);
        waitDrain(50, "halfLoads");

        $display("[TB] meta queue full");
        memHold = 1'b1; minLat = 1; maxLat = 1;
        base = acceptedCount;
        for (int i = 0; i < DEPTH + 1; i++) pushLoad(32'h10 + 32'(4 * i), 2'b10, 1'b0);
        applyStimulus(8);
        checkOutput("fullAccepts", 32'(acceptedCount - base), 32'(DEPTH));
        checkOutput("fullReqReady", 32'(req_ready), 32'd0);
        firstRspCycle = -1;
        memHold = 1'b0;
        waitDrain(60, "fullQueue");
        checkOutput("readyRecoveryCycle", 32'(lastAcceptCycle), 32'(firstRspCycle));

        $display("[TB] consumer stall with three results pending");
        rspReadyMode = 2;
        base = rspCount;
        pushLoad(32'h203, 2'b00, 1'b0);
        pushLoad(32'h302, 2'b01, 1'b1);
        pushLoad(32'h100, 2'b10, 1'b0);
        applyStimulus(8);
        checkOutput("stallRspValid", 32'(rsp_valid), 32'd1);
        checkOutput("stallNoPops", 32'(rspCount - base), 32'd0);
        for (int k = 0; k < 2; k++) begin
            if (expQ.size() > 0) checkOutput("stallHeadData", rsp_data, expQ[0].data);
            else begin
                checks++; errors++;
                $display("[TB] FAIL stallHeadData: got empty scoreboard, expected 3 pending");
            end
            applyStimulus(3);
        end
        rspReadyMode = 0;
        waitDrain(60, "stall");
        checkOutput("stallAllReturned", 32'(rspCount - base), 32'd3);

        $display("[TB] misaligned word/byte sequence");
        memArr[0] = 32'h1122_3344;
        memArr[1] = 32'hA5B6_C7D8;
        base = memReqCount;
        pushLoad(32'h0, 2'b10, 1'b0);
        pushLoad(32'h2, 2'b10, 1'b0);
        pushLoad(32'h5, 2'b00, 1'b0);
        waitDrain(60, "misalign");
        checkOutput("misalignMemReqs", 32'(memReqCount - base), 32'(MISALIGN_MEM_REQS));

        $display("[TB] random traffic with mid-run reset");
        for (int i = 0; i < 256; i++) memArr[i] = $urandom;
        memReadyRandom = 1'b1; reqIdleRandom = 1'b1; rspReadyMode = 1;
        minLat = 1; maxLat = 5;
        for (int i = 0; i < 200; i++)
            pushLoad(32'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        applyStimulus(60);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("midResetRspData", rsp_data, 32'd0);
        checkOutput("midResetRspErr", 32'(rsp_err), 32'd0);
        stimQ.delete();
        expQ.delete();
        memPending.delete();
        req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midResetReqReady", 32'(req_ready), 32'd1);
        checkOutput("midResetMemReqValid", 32'(mem_req_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            pushLoad(32'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        waitDrain(3000, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
